accumulator_ext: RTL and testbench

Parametrised next-generation CPU accumulator. It keeps the existing accumulator operations: write, INC/DEC with carry/borrow, and plain rotates. It adds add/subtract with flags, rotate-through-carry, flag set/clear, BCD decimal adjust, and a multi-cycle rotate-by-N with busy/done handshake. It sits in the datapath between the instruction decoder (opcode, select) and the internal data bus (data_in/out).

---
 rtl/accumulator_ext.sv | 158 +++++++++++++++
 tb/tb_accumulator_ext.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/accumulator_ext.sv
// Parametrised CPU accumulator: arithmetic with carry/borrow flags, rotates,
// BCD adjust and a multi-cycle rotate-by-N with a busy/done handshake.
module accumulator_ext #(
   parameter int WIDTH  = 4,
   parameter bit BCD_EN = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             select,
   input  logic [WIDTH-1:0] data_in,
   input  logic [3:0]       opcode,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             borrow,
   output logic             busy,
   output logic             done
);

   localparam int CW     = $clog2(WIDTH) + 1;
   localparam bit DAA_ON = BCD_EN && (WIDTH == 4);

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,  OP_WRITE = 4'd1,  OP_INC  = 4'd2,  OP_DEC  = 4'd3,
      OP_ROTL  = 4'd4,  OP_ROTR  = 4'd5,  OP_ADD  = 4'd6,  OP_SUB  = 4'd7,
      OP_RAL   = 4'd8,  OP_RAR   = 4'd9,  OP_CLC  = 4'd10, OP_STC  = 4'd11,
      OP_DAA   = 4'd12, OP_ROTN  = 4'd13, OP_CLR  = 4'd14, OP_RSVD = 4'd15
   } opcode_e;

   typedef enum logic {IDLE, ROT} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             carry_q, carry_d;
   logic             borrow_q, borrow_d;
   logic             done_q, done_d;
   logic [CW-1:0]    count_q, count_d;

   logic [WIDTH:0]   incSum, addSum, subRhs, daaSum;
   logic [WIDTH-1:0] subDiff, rotLeft;
   logic [CW-1:0]    rotCount;
   logic             daaNeeded;

   always_comb begin
      incSum    = {1'b0, acc_q} + (WIDTH+1)'(1);
      addSum    = {1'b0, acc_q} + {1'b0, data_in} + (WIDTH+1)'(carry_q);
      subRhs    = {1'b0, data_in} + (WIDTH+1)'(borrow_q);
      subDiff   = acc_q - data_in - WIDTH'(borrow_q);
      daaSum    = {1'b0, acc_q} + (WIDTH+1)'(6);
      daaNeeded = (32'(acc_q) > 32'd9) || carry_q;
      rotLeft   = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
      rotCount  = CW'(32'(data_in) % WIDTH);
   end

   // Next-state logic: decoder opcodes are only honoured while idle and selected;
   // an in-flight ROTN rotates once per edge and ignores the decoder entirely.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      carry_d  = carry_q;
      borrow_d = borrow_q;
      count_d  = count_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (select) begin
               case (opcode)
                  OP_WRITE: acc_d = data_in;
                  OP_INC: begin
                     acc_d   = incSum[WIDTH-1:0];
                     carry_d = incSum[WIDTH];
                  end
                  OP_DEC: begin
                     acc_d    = acc_q - WIDTH'(1);
                     borrow_d = (acc_q == '0);
                  end
                  OP_ROTL: acc_d = rotLeft;
                  OP_ROTR: acc_d = {acc_q[0], acc_q[WIDTH-1:1]};
                  OP_ADD: begin
                     acc_d   = addSum[WIDTH-1:0];
                     carry_d = addSum[WIDTH];
                  end
                  OP_SUB: begin
                     acc_d    = subDiff;
                     borrow_d = ({1'b0, acc_q} < subRhs);
                  end
                  OP_RAL: begin
                     acc_d   = {acc_q[WIDTH-2:0], carry_q};
                     carry_d = acc_q[WIDTH-1];
                  end
                  OP_RAR: begin
                     acc_d   = {carry_q, acc_q[WIDTH-1:1]};
                     carry_d = acc_q[0];
                  end
                  OP_CLC: begin
                     carry_d  = 1'b0;
                     borrow_d = 1'b0;
                  end
                  OP_STC: carry_d = 1'b1;
                  OP_DAA: begin
                     if (DAA_ON && daaNeeded) begin
                        acc_d = daaSum[WIDTH-1:0];
                        if (daaSum[WIDTH]) carry_d = 1'b1;
                     end
                  end
                  OP_ROTN: begin
                     if (rotCount == '0) begin
                        done_d = 1'b1;
                     end else begin
                        state_d = ROT;
                        count_d = rotCount;
                     end
                  end
                  OP_CLR: begin
                     acc_d    = '0;
                     carry_d  = 1'b0;
                     borrow_d = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
         ROT: begin
            acc_d   = rotLeft;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
         done_q   <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         carry_q  <= carry_d;
         borrow_q <= borrow_d;
         done_q   <= done_d;
         count_q  <= count_d;
      end
   end

   assign out    = select ? acc_q : '0;
   assign carry  = carry_q;
   assign borrow = borrow_q;
   assign busy   = (state_q == ROT);
   assign done   = done_q;

endmodule

// File: tb/tb_accumulator_ext.sv
// Self-checking bench for accumulator_ext (WIDTH=4): vector table driven through
// a scoreboard queue, plus hand-written ROTN/reset/select sequences.
module tb_accumulator_ext;

   localparam int W = 4;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         select = 1'b0;
   logic [W-1:0] data_in = '0;
   logic [3:0]   opcode = 4'd0;
   logic [W-1:0] out;
   logic         carry, borrow, busy, done;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] data;
      logic         sel;
      logic [W-1:0] expOut;
      logic         expCarry;
      logic         expBorrow;
      logic         expBusy;
      logic         expDone;
   } vec_t;

   vec_t vecs[$];
   vec_t scoreboard[$];
   int   assertCount = 0;
   int   failCount = 0;
   int   vecIdx = 0;

   accumulator_ext #(.WIDTH(W), .BCD_EN(1'b1)) dut (
      .clock(clock), .reset(reset), .select(select), .data_in(data_in),
      .opcode(opcode), .out(out), .carry(carry), .borrow(borrow),
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: act=timeout req=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkField(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s #%0d: actual=%0h required=%0h", name, idx, act, exp);
      end
   endtask

   task automatic addVec(input logic [3:0] op, input logic [W-1:0] d, input logic s,
                         input logic [W-1:0] eo, input logic ec, input logic eb,
                         input logic ebusy, input logic edone);
      vec_t v;
      v.op = op; v.data = d; v.sel = s; v.expOut = eo; v.expCarry = ec;
      v.expBorrow = eb; v.expBusy = ebusy; v.expDone = edone;
      vecs.push_back(v);
   endtask

   task automatic checkOutput();
      vec_t e;
      if (scoreboard.size() == 0) begin
         checkField("scoreboard_empty", vecIdx, 32'd1, 32'd0);
         return;
      end
      e = scoreboard.pop_front();
      checkField("out", vecIdx, 32'(out), 32'(e.expOut));
      checkField("carry", vecIdx, 32'(carry), 32'(e.expCarry));
      checkField("borrow", vecIdx, 32'(borrow), 32'(e.expBorrow));
      checkField("busy", vecIdx, 32'(busy), 32'(e.expBusy));
      checkField("done", vecIdx, 32'(done), 32'(e.expDone));
      vecIdx++;
   endtask

   // Called at a negedge: drive, let one rising edge pass, sample at next negedge.
   task automatic applyStimulus(input vec_t v);
      scoreboard.push_back(v);
      opcode  = v.op;
      data_in = v.data;
      select  = v.sel;
      @(posedge clock);
      @(negedge clock);
      checkOutput();
   endtask

   task automatic runVecs();
      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);
      vecs.delete();
   endtask

   initial begin
      int accModel;
      @(negedge clock);
      select = 1'b1;
      checkField("reset_out", 0, 32'(out), 32'd0);
      checkField("reset_carry", 0, 32'(carry), 32'd0);
      checkField("reset_borrow", 0, 32'(borrow), 32'd0);
      checkField("reset_busy", 0, 32'(busy), 32'd0);
      checkField("reset_done", 0, 32'(done), 32'd0);
      reset = 1'b0;

      // INC sweep with wrap
      addVec(4'd1, 4'h0, 1, 4'h0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         accModel = (i + 1) % 16;
         addVec(4'd2, 4'h0, 1, 4'(accModel), (i == 15), 0, 0, 0);
         addVec(4'd0, 4'h0, 1, 4'(accModel), (i == 15), 0, 0, 0);
      end
      // ADD / DAA
      addVec(4'd10, 4'h0, 1, 4'h0, 0, 0, 0, 0);
      addVec(4'd1,  4'h7, 1, 4'h7, 0, 0, 0, 0);
      addVec(4'd6,  4'h5, 1, 4'hC, 0, 0, 0, 0);
      addVec(4'd12, 4'h0, 1, 4'h2, 1, 0, 0, 0);
      addVec(4'd6,  4'h0, 1, 4'h3, 0, 0, 0, 0);
      addVec(4'd1,  4'h9, 1, 4'h9, 0, 0, 0, 0);
      addVec(4'd12, 4'h0, 1, 4'h9, 0, 0, 0, 0);
      addVec(4'd1,  4'hF, 1, 4'hF, 0, 0, 0, 0);
      addVec(4'd6,  4'h1, 1, 4'h0, 1, 0, 0, 0);
      // SUB
      addVec(4'd10, 4'h0, 1, 4'h0, 0, 0, 0, 0);
      addVec(4'd1,  4'h3, 1, 4'h3, 0, 0, 0, 0);
      addVec(4'd7,  4'h5, 1, 4'hE, 0, 1, 0, 0);
      addVec(4'd7,  4'h0, 1, 4'hD, 0, 0, 0, 0);
      addVec(4'd1,  4'hF, 1, 4'hF, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++)
         addVec(4'd3, 4'h0, 1, 4'((15 - i + 15) % 16), 0, (i == 15), 0, 0);
      // RAL / RAR
      addVec(4'd10, 4'h0, 1, 4'hF, 0, 0, 0, 0);
      addVec(4'd11, 4'h0, 1, 4'hF, 1, 0, 0, 0);
      addVec(4'd1,  4'hB, 1, 4'hB, 1, 0, 0, 0);
      addVec(4'd8,  4'h0, 1, 4'h7, 1, 0, 0, 0);
      addVec(4'd8,  4'h0, 1, 4'hF, 0, 0, 0, 0);
      addVec(4'd9,  4'h0, 1, 4'h7, 1, 0, 0, 0);
      runVecs();

      // ROTN by 3 with an INC issued mid-rotation
      addVec(4'd1,  4'hB, 1, 4'hB, 1, 0, 0, 0);
      addVec(4'd13, 4'h3, 1, 4'hB, 1, 0, 1, 0);
      addVec(4'd2,  4'h0, 1, 4'h7, 1, 0, 1, 0);
      addVec(4'd0,  4'h0, 1, 4'hE, 1, 0, 1, 0);
      addVec(4'd0,  4'h0, 1, 4'hD, 1, 0, 0, 1);
      addVec(4'd0,  4'h0, 1, 4'hD, 1, 0, 0, 0);
      // ROTN n=0 (4 mod 4), then plain rotates, reserved opcode
      addVec(4'd13, 4'h4, 1, 4'hD, 1, 0, 0, 1);
      addVec(4'd2,  4'h0, 1, 4'hE, 0, 0, 0, 0);
      addVec(4'd4,  4'h0, 1, 4'hD, 0, 0, 0, 0);
      addVec(4'd5,  4'h0, 1, 4'hE, 0, 0, 0, 0);
      addVec(4'd15, 4'h3, 1, 4'hE, 0, 0, 0, 0);
      // select gating
      addVec(4'd1,  4'h5, 0, 4'h0, 0, 0, 0, 0);
      addVec(4'd0,  4'h0, 1, 4'hE, 0, 0, 0, 0);
      addVec(4'd11, 4'h0, 1, 4'hE, 1, 0, 0, 0);
      addVec(4'd14, 4'h0, 1, 4'h0, 0, 0, 0, 0);
      // reset during ROTN
      addVec(4'd11, 4'h0, 1, 4'h0, 1, 0, 0, 0);
      addVec(4'd1,  4'hB, 1, 4'hB, 1, 0, 0, 0);
      addVec(4'd13, 4'h3, 1, 4'hB, 1, 0, 1, 0);
      runVecs();

      reset = 1'b1;
      #1;
      checkField("async_rst_out", vecIdx, 32'(out), 32'd0);
      checkField("async_rst_carry", vecIdx, 32'(carry), 32'd0);
      checkField("async_rst_busy", vecIdx, 32'(busy), 32'd0);
      @(negedge clock);
      addVec(4'd0, 4'h0, 1, 4'h0, 0, 0, 0, 0);
      runVecs();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) addVec(4'd0, 4'h0, 1, 4'h0, 0, 0, 0, 0);
      runVecs();

      checkField("scoreboard_drained", vecIdx, 32'(scoreboard.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
